// File: rtl/systolic_is_ctrl_if.sv
// -----------------------------------------------------------------------------
// systolic_is_ctrl_if
// Bundle between the input-stationary systolic array controller and its
// surroundings (job request, weight/activation memories, array edge buses).
//
// Parameters: D_W (element width), N (array dimension), CNT_W (count/address
// width).
//
// Signals:
//   start, num_vec        job request and vector count
//   busy, done, phase     job status
//   w_rd_en, w_addr       weight memory read strobe / row index
//   w_rdata               weight row, valid one cycle after w_rd_en
//   a_rd_en, a_addr       activation memory read strobe / vector index
//   a_rdata               activation vector, valid one cycle after a_rd_en
//   load_weight, m1       array weight capture enable and top-edge weight bus
//   m0                    left-edge activation bus
//
// Modports: master = controller side, slave = environment side.
// -----------------------------------------------------------------------------
interface systolic_is_ctrl_if #(
    parameter int D_W   = 8,
    parameter int N     = 8,
    parameter int CNT_W = 16
);
    logic                 start;
    logic [CNT_W-1:0]     num_vec;
    logic                 busy;
    logic                 done;
    logic                 w_rd_en;
    logic [CNT_W-1:0]     w_addr;
    logic [N*D_W-1:0]     w_rdata;
    logic                 a_rd_en;
    logic [CNT_W-1:0]     a_addr;
    logic [N*D_W-1:0]     a_rdata;
    logic                 load_weight;
    logic [N*D_W-1:0]     m1;
    logic [N*D_W-1:0]     m0;
    logic [1:0]           phase;

    modport master (
        input  start, num_vec, w_rdata, a_rdata,
        output busy, done, w_rd_en, w_addr, a_rd_en, a_addr,
               load_weight, m1, m0, phase
    );

    modport slave (
        output start, num_vec, w_rdata, a_rdata,
        input  busy, done, w_rd_en, w_addr, a_rd_en, a_addr,
               load_weight, m1, m0, phase
    );
endinterface

// File: rtl/systolic_is_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_is_ctrl
// Sequencer for an N x N input-stationary systolic array: loads N weight rows
// (bottom row first), streams num_vec activation vectors onto the left edge,
// drains the array and pulses done.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    systolic_is_ctrl_if.master (job control, memory reads, edge buses)
//
// Build option: define SYSTOLIC_IS_SKEW_EN to delay m0 row r by r cycles and
// lengthen the drain from 2N-1 to 3N-2 cycles.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start
// S_LOAD_W  | N weight reads (rows N-1..0), then one cycle for last capture
// S_COMPUTE | num_vec activation reads, then one cycle for last vector
// S_DRAIN   | m0 held at zero while the array empties (down-counter)
// S_DONE    | single-cycle done pulse
// -----------------------------------------------------------------------------
module systolic_is_ctrl #(
    parameter int D_W   = 8,
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    systolic_is_ctrl_if.master   bus
);

`ifdef SYSTOLIC_IS_SKEW_EN
    localparam int DRAIN_CYC = 3*N - 2;
`else
    localparam int DRAIN_CYC = 2*N - 1;
`endif

    localparam logic [CNT_W-1:0] W_LAST     = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   nv_q, nv_d;
    // tail marks the extra cycle after the last read, while its data lands
    logic               tail_q, tail_d;
    logic               w_vld_q;
    logic               a_vld_q;

    logic               w_rd_en_s;
    logic               a_rd_en_s;
    logic               busy_s;
    logic               done_s;
    logic [1:0]         phase_s;
    logic [N*D_W-1:0]   m0_raw;
    logic [N*D_W-1:0]   m0_s;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nv_q    <= '0;
            tail_q  <= 1'b0;
            w_vld_q <= 1'b0;
            a_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nv_q    <= nv_d;
            tail_q  <= tail_d;
            w_vld_q <= w_rd_en_s;
            a_vld_q <= a_rd_en_s;
        end
    end

    // next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nv_d    = nv_q;
        tail_d  = tail_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD_W;
                    nv_d    = bus.num_vec;
                    cnt_d   = W_LAST;
                    tail_d  = 1'b0;
                end
            end
            S_LOAD_W: begin
                if (tail_q) begin
                    tail_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = (nv_q == '0) ? S_DONE : S_COMPUTE;
                end else if (cnt_q == '0) begin
                    tail_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_COMPUTE: begin
                // cnt_q stops at num_vec-1, so it cannot wrap even at max count
                if (tail_q) begin
                    tail_d  = 1'b0;
                    cnt_d   = DRAIN_LAST;
                    state_d = S_DRAIN;
                end else if (cnt_q == nv_q - ONE) begin
                    tail_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tail_d  = 1'b0;
            end
        endcase
    end

    // outputs
    always_comb begin
        w_rd_en_s = 1'b0;
        a_rd_en_s = 1'b0;
        busy_s    = 1'b1;
        done_s    = 1'b0;
        phase_s   = 2'd0;
        case (state_q)
            S_IDLE:    busy_s = 1'b0;
            S_LOAD_W:  begin phase_s = 2'd1; w_rd_en_s = !tail_q; end
            S_COMPUTE: begin phase_s = 2'd2; a_rd_en_s = !tail_q; end
            S_DRAIN:   phase_s = 2'd2;
            S_DONE:    begin phase_s = 2'd3; done_s = 1'b1; end
            default:   busy_s = 1'b0;
        endcase
    end

    assign bus.busy        = busy_s;
    assign bus.done        = done_s;
    assign bus.phase       = phase_s;
    assign bus.w_rd_en     = w_rd_en_s;
    assign bus.w_addr      = w_rd_en_s ? cnt_q : '0;
    assign bus.a_rd_en     = a_rd_en_s;
    assign bus.a_addr      = a_rd_en_s ? cnt_q : '0;
    assign bus.load_weight = w_vld_q;

    // memory read data arrives one cycle after the strobe; gate it with the
    // delayed strobe so the edge buses are zero whenever nothing is valid
    assign bus.m1 = w_vld_q ? bus.w_rdata : '0;
    assign m0_raw = a_vld_q ? bus.a_rdata : '0;

`ifdef SYSTOLIC_IS_SKEW_EN
    assign m0_s[D_W-1:0] = m0_raw[D_W-1:0];

    for (genvar r = 1; r < N; r++) begin : g_skew
        logic [D_W-1:0] sr_q [r];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < r; k++) sr_q[k] <= '0;
            end else begin
                sr_q[0] <= m0_raw[r*D_W +: D_W];
                for (int k = 1; k < r; k++) sr_q[k] <= sr_q[k-1];
            end
        end

        assign m0_s[r*D_W +: D_W] = sr_q[r-1];
    end
`else
    assign m0_s = m0_raw;
`endif

    assign bus.m0 = m0_s;

endmodule

// File: tb/tb_systolic_is_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_is_ctrl
// Directed bench for systolic_is_ctrl with N=4, D_W=8, CNT_W=16. A small
// registered memory model answers the read strobes; a negedge recorder logs
// strobes, edge-bus values, done pulses and phase per cycle, and each test
// task compares that log against hand-derived cycle offsets.
// -----------------------------------------------------------------------------
module tb_systolic_is_ctrl;
    localparam int D_W   = 8;
    localparam int N     = 4;
    localparam int CNT_W = 16;
`ifdef SYSTOLIC_IS_SKEW_EN
    localparam int DRAIN_CYC = 10;
`else
    localparam int DRAIN_CYC = 7;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] wmem [4] = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
    logic [31:0] amem [8] = '{32'h04030201, 32'h14131211, 32'h24232221, 32'h34333231,
                              32'h44434241, 32'h54535251, 32'h64636261, 32'h74737271};

    systolic_is_ctrl_if #(.D_W(D_W), .N(N), .CNT_W(CNT_W)) bus ();

    systolic_is_ctrl #(.D_W(D_W), .N(N), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // memory model: one-cycle read latency, junk when not strobed
    always @(posedge clk) begin
        bus.w_rdata <= bus.w_rd_en ? wmem[bus.w_addr[1:0]] : 32'hDEADBEEF;
        bus.a_rdata <= bus.a_rd_en ? amem[bus.a_addr[2:0]] : 32'hBAADF00D;
    end

    int               wa_c[$], lw_c[$], aa_c[$], m0_c[$], dn_c[$], bf_c[$];
    logic [CNT_W-1:0] wa_v[$], aa_v[$];
    logic [31:0]      lw_v[$], m0_v[$];
    logic [1:0]       ph_at[int];
    logic             busy_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.w_rd_en)     begin wa_c.push_back(cyc); wa_v.push_back(bus.w_addr); end
        if (bus.load_weight) begin lw_c.push_back(cyc); lw_v.push_back(bus.m1); end
        if (bus.a_rd_en)     begin aa_c.push_back(cyc); aa_v.push_back(bus.a_addr); end
        if (bus.m0 != '0)    begin m0_c.push_back(cyc); m0_v.push_back(bus.m0); end
        if (bus.done)        dn_c.push_back(cyc);
        if (busy_prev && !bus.busy) bf_c.push_back(cyc);
        busy_prev = bus.busy;
        ph_at[cyc] = bus.phase;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_trace();
        wa_c.delete(); lw_c.delete(); aa_c.delete(); m0_c.delete();
        dn_c.delete(); bf_c.delete(); wa_v.delete(); aa_v.delete();
        lw_v.delete(); m0_v.delete(); ph_at.delete();
    endtask

    task automatic launch(input logic [CNT_W-1:0] nv, output int s);
        bus.num_vec = nv;
        bus.start   = 1'b1;
        s = cyc + 1;
        step();
        bus.start   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && dn_c.size() == 0; i++) step();
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++;
        if ({bus.busy, bus.done, bus.w_rd_en, bus.a_rd_en, bus.load_weight, bus.phase} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {bus.busy, bus.done, bus.w_rd_en, bus.a_rd_en, bus.load_weight, bus.phase});
        end
        n_cmp++;
        if (bus.m0 !== 32'h0 || bus.m1 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_bus: got m0=%h m1=%h expected 0", bus.m0, bus.m1);
        end
        rst_n = 1'b1;
        step();
        step();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.phase !== 2'd0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b phase=%0d expected 0/0", bus.busy, bus.phase);
        end
    endtask

    task automatic test_basic();
        int s;
        int ph_off[6] = '{0, 4, 5, 9, 9 + DRAIN_CYC - 2, 10 + DRAIN_CYC - 1};
        logic [1:0] ph_exp[6] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
        clear_trace();
        launch(16'd3, s);
        bus.num_vec = 16'd9;
        wait_done(80);
        step();
        step();
        n_cmp++;
        if (wa_c.size() != 4) begin n_err++; $display("FAIL basic_w_count: got %0d expected 4", wa_c.size()); end
        for (int i = 0; i < 4 && i < wa_c.size(); i++) begin
            n_cmp++;
            if (wa_v[i] !== 16'(3 - i) || wa_c[i] != s + i) begin
                n_err++;
                $display("FAIL basic_w_addr[%0d]: got %0d@%0d expected %0d@%0d", i, wa_v[i], wa_c[i], 3 - i, s + i);
            end
        end
        n_cmp++;
        if (lw_c.size() != 4) begin n_err++; $display("FAIL basic_lw_count: got %0d expected 4", lw_c.size()); end
        for (int i = 0; i < 4 && i < lw_c.size(); i++) begin
            n_cmp++;
            if (lw_v[i] !== wmem[3 - i] || lw_c[i] != s + 1 + i) begin
                n_err++;
                $display("FAIL basic_m1[%0d]: got %h@%0d expected %h@%0d", i, lw_v[i], lw_c[i], wmem[3 - i], s + 1 + i);
            end
        end
        n_cmp++;
        if (aa_c.size() != 3) begin n_err++; $display("FAIL basic_a_count: got %0d expected 3", aa_c.size()); end
        for (int i = 0; i < 3 && i < aa_c.size(); i++) begin
            n_cmp++;
            if (aa_v[i] !== 16'(i) || aa_c[i] != s + 5 + i) begin
                n_err++;
                $display("FAIL basic_a_addr[%0d]: got %0d@%0d expected %0d@%0d", i, aa_v[i], aa_c[i], i, s + 5 + i);
            end
        end
`ifndef SYSTOLIC_IS_SKEW_EN
        n_cmp++;
        if (m0_c.size() != 3) begin n_err++; $display("FAIL basic_m0_count: got %0d expected 3", m0_c.size()); end
        for (int i = 0; i < 3 && i < m0_c.size(); i++) begin
            n_cmp++;
            if (m0_v[i] !== amem[i] || m0_c[i] != s + 6 + i) begin
                n_err++;
                $display("FAIL basic_m0[%0d]: got %h@%0d expected %h@%0d", i, m0_v[i], m0_c[i], amem[i], s + 6 + i);
            end
        end
`endif
        n_cmp++;
        if (dn_c.size() != 1 || dn_c[0] != s + 9 + DRAIN_CYC) begin
            n_err++;
            $display("FAIL basic_done: got %0d pulses first@%0d expected 1@%0d", dn_c.size(), dn_c.size() ? dn_c[0] : -1, s + 9 + DRAIN_CYC);
        end
        n_cmp++;
        if (bf_c.size() != 1 || bf_c[0] != s + 10 + DRAIN_CYC) begin
            n_err++;
            $display("FAIL basic_busy_fall: got %0d falls first@%0d expected 1@%0d", bf_c.size(), bf_c.size() ? bf_c[0] : -1, s + 10 + DRAIN_CYC);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (!ph_at.exists(s + ph_off[i]) || ph_at[s + ph_off[i]] !== ph_exp[i]) begin
                n_err++;
                $display("FAIL basic_phase@+%0d: got %0d expected %0d", ph_off[i],
                         ph_at.exists(s + ph_off[i]) ? ph_at[s + ph_off[i]] : 2'bxx, ph_exp[i]);
            end
        end
    endtask

    task automatic test_zero_vec();
        int s;
        clear_trace();
        launch(16'd0, s);
        wait_done(40);
        step();
        step();
        n_cmp++;
        if (wa_c.size() != 4 || lw_c.size() != 4 || lw_c[3] != s + 4) begin
            n_err++;
            $display("FAIL zero_load: got w=%0d lw=%0d expected 4/4 last lw@%0d", wa_c.size(), lw_c.size(), s + 4);
        end
        n_cmp++;
        if (aa_c.size() != 0 || m0_c.size() != 0) begin
            n_err++;
            $display("FAIL zero_no_act: got a_rd=%0d m0=%0d expected 0/0", aa_c.size(), m0_c.size());
        end
        n_cmp++;
        if (dn_c.size() != 1 || dn_c[0] != s + 5) begin
            n_err++;
            $display("FAIL zero_done: got %0d pulses first@%0d expected 1@%0d", dn_c.size(), dn_c.size() ? dn_c[0] : -1, s + 5);
        end
        n_cmp++;
        if (bf_c.size() != 1 || bf_c[0] != s + 6) begin
            n_err++;
            $display("FAIL zero_busy_fall: got %0d falls expected 1@%0d", bf_c.size(), s + 6);
        end
    endtask

    task automatic test_ignore_start();
        int s;
        bit hit = 0;
        clear_trace();
        launch(16'd2, s);
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (bus.phase == 2'd2) hit = 1;
        end
        bus.num_vec = 16'd7;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            if (bus.done) begin
                hit = 1;
                bus.num_vec = 16'd5;
                bus.start   = 1'b1;
                step();
                bus.start   = 1'b0;
            end
        end
        repeat (25) step();
        n_cmp++;
        if (dn_c.size() != 1) begin n_err++; $display("FAIL ignore_done_count: got %0d expected 1", dn_c.size()); end
        n_cmp++;
        if (wa_c.size() != 4 || aa_c.size() != 2) begin
            n_err++;
            $display("FAIL ignore_reads: got w=%0d a=%0d expected 4/2", wa_c.size(), aa_c.size());
        end
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.phase !== 2'd0) begin
            n_err++;
            $display("FAIL ignore_idle: got busy=%b phase=%0d expected 0/0", bus.busy, bus.phase);
        end
    endtask

    task automatic test_reset_mid();
        int  s;
        bit  hit = 0;
        clear_trace();
        launch(16'd3, s);
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            if (bus.a_rd_en && bus.a_addr == 16'd1) hit = 1;
        end
        n_cmp++;
        if (!hit) begin n_err++; $display("FAIL midrst_reach: got no a_addr=1 expected a_addr=1 within 30 cycles"); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.w_rd_en, bus.a_rd_en, bus.load_weight, bus.phase} !== 7'd0) begin
            n_err++;
            $display("FAIL midrst_ctrl: got %b expected 0000000",
                     {bus.busy, bus.done, bus.w_rd_en, bus.a_rd_en, bus.load_weight, bus.phase});
        end
        n_cmp++;
        if (bus.m0 !== 32'h0 || bus.m1 !== 32'h0 || bus.a_addr !== 16'h0 || bus.w_addr !== 16'h0) begin
            n_err++;
            $display("FAIL midrst_bus: got m0=%h m1=%h a=%h w=%h expected 0", bus.m0, bus.m1, bus.a_addr, bus.w_addr);
        end
        clear_trace();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (dn_c.size() != 0) begin n_err++; $display("FAIL midrst_no_done: got %0d expected 0", dn_c.size()); end
        clear_trace();
        launch(16'd2, s);
        wait_done(60);
        n_cmp++;
        if (wa_c.size() != 4 || aa_c.size() != 2 || aa_v[0] !== 16'd0 || aa_v[1] !== 16'd1) begin
            n_err++;
            $display("FAIL midrst_rerun_reads: got w=%0d a=%0d expected 4 and a_addr 0,1", wa_c.size(), aa_c.size());
        end
`ifndef SYSTOLIC_IS_SKEW_EN
        n_cmp++;
        if (m0_v.size() != 2 || m0_v[0] !== amem[0] || m0_v[1] !== amem[1]) begin
            n_err++;
            $display("FAIL midrst_rerun_m0: got %0d vectors expected 2 (%h,%h)", m0_v.size(), amem[0], amem[1]);
        end
`endif
        n_cmp++;
        if (dn_c.size() != 1 || dn_c[0] != s + 8 + DRAIN_CYC) begin
            n_err++;
            $display("FAIL midrst_rerun_done: got %0d pulses first@%0d expected 1@%0d", dn_c.size(), dn_c.size() ? dn_c[0] : -1, s + 8 + DRAIN_CYC);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int s1, s2;
        clear_trace();
        launch(16'd5, s1);
        wait_done(80);
        step();
        launch(16'd1, s2);
        for (int i = 0; i < 60 && dn_c.size() < 2; i++) step();
        n_cmp++;
        if (wa_c.size() != 8) begin n_err++; $display("FAIL b2b_w_count: got %0d expected 8", wa_c.size()); end
        for (int i = 0; i < 4 && i + 4 < wa_c.size(); i++) begin
            n_cmp++;
            if (wa_v[i + 4] !== 16'(3 - i) || wa_c[i + 4] != s2 + i) begin
                n_err++;
                $display("FAIL b2b_w2_addr[%0d]: got %0d@%0d expected %0d@%0d", i, wa_v[i + 4], wa_c[i + 4], 3 - i, s2 + i);
            end
        end
        n_cmp++;
        if (aa_c.size() != 6 || aa_v[4] !== 16'd4 || aa_v[5] !== 16'd0 || aa_c[5] != s2 + 5) begin
            n_err++;
            $display("FAIL b2b_a_reads: got %0d reads expected 6, last a_addr 0@%0d", aa_c.size(), s2 + 5);
        end
`ifndef SYSTOLIC_IS_SKEW_EN
        n_cmp++;
        if (m0_v.size() != 6 || m0_v[4] !== amem[4] || m0_v[5] !== amem[0] || m0_c[5] != s2 + 6) begin
            n_err++;
            $display("FAIL b2b_m0: got %0d vectors expected 6 ending %h@%0d", m0_v.size(), amem[0], s2 + 6);
        end
`endif
        n_cmp++;
        if (dn_c.size() != 2 || dn_c[0] != s1 + 11 + DRAIN_CYC || dn_c[1] != s2 + 7 + DRAIN_CYC) begin
            n_err++;
            $display("FAIL b2b_done: got %0d pulses expected 2 at %0d,%0d", dn_c.size(), s1 + 11 + DRAIN_CYC, s2 + 7 + DRAIN_CYC);
        end
        step();
    endtask

`ifdef SYSTOLIC_IS_SKEW_EN
    task automatic test_skew();
        int s;
        logic [7:0] e;
        clear_trace();
        launch(16'd1, s);
        for (int k = 0; k < 20; k++) begin
            step();
            for (int r = 0; r < 4; r++) begin
                e = (cyc == s + 6 + r) ? 8'(r + 1) : 8'h00;
                n_cmp++;
                if (bus.m0[r*8 +: 8] !== e) begin
                    n_err++;
                    $display("FAIL skew_row%0d@+%0d: got %h expected %h", r, cyc - s, bus.m0[r*8 +: 8], e);
                end
            end
        end
        n_cmp++;
        if (dn_c.size() != 1 || dn_c[0] != s + 17) begin
            n_err++;
            $display("FAIL skew_drain: got %0d pulses first@%0d expected 1@%0d", dn_c.size(), dn_c.size() ? dn_c[0] : -1, s + 17);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start   = 1'b0;
        bus.num_vec = '0;
        test_reset();
        test_basic();
        test_zero_vec();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
`ifdef SYSTOLIC_IS_SKEW_EN
        test_skew();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_is_ctrl.md
SYSTOLIC_IS_CTRL -- requirements
Module: systolic_is_ctrl

Interface
REQ-001 Parameter D_W, default 8: data element width in bits.
REQ-002 Parameter N, default 8: array dimension (rows = cols = N).
REQ-003 Parameter CNT_W, default 16: width of the vector-count input and address outputs.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to run one job; sampled only in IDLE.
REQ-007 num_vec  in  CNT_W  number of activation vectors in the job; sampled with start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse when a job completes.
REQ-010 w_rd_en, w_addr  out  1, CNT_W  weight memory read strobe and row index.
REQ-011 w_rdata  in  N*D_W  weight row; valid exactly 1 cycle after w_rd_en.
REQ-012 a_rd_en, a_addr  out  1, CNT_W  activation memory read strobe and vector index.
REQ-013 a_rdata  in  N*D_W  activation vector; valid exactly 1 cycle after a_rd_en.
REQ-014 load_weight  out  1  array weight-capture enable.
REQ-015 m1  out  N*D_W  top-edge weight bus; slice c = column c.
REQ-016 m0  out  N*D_W  left-edge activation bus; slice r = row r.
REQ-017 phase  out  2  0 = idle, 1 = weight load, 2 = compute/drain, 3 = done.

Function
REQ-018 FSM states: IDLE, LOAD_W, COMPUTE, DRAIN, DONE; phase encodes IDLE=0, LOAD_W=1, COMPUTE and DRAIN=2, DONE=3.
REQ-019 IDLE -> LOAD_W on start=1. start is ignored while busy=1.
REQ-020 LOAD_W: w_rd_en is high for N consecutive cycles, with w_addr = N-1, N-2, ..., 0 (bottom row first).
REQ-021 load_weight is high for exactly N cycles, each delayed 1 cycle from the matching w_rd_en; m1 = registered w_rdata in those cycles and 0 otherwise.
REQ-022 LOAD_W -> COMPUTE in the cycle after the last load_weight; if the latched num_vec = 0, LOAD_W -> DONE instead.
REQ-023 COMPUTE: a_rd_en is high for num_vec consecutive cycles, with a_addr = 0..num_vec-1; m0 = registered a_rdata, 1 cycle after each a_rd_en.
REQ-024 m0 is 0 whenever no activation is valid; load_weight is never high in COMPUTE or DRAIN.
REQ-025 COMPUTE -> DRAIN after the last vector is presented; DRAIN holds m0 = 0 for DRAIN_CYC cycles, then enters DONE.
REQ-026 DRAIN_CYC = 2N-1 without skew and 3N-2 with skew (see REQ-033).
REQ-027 DONE lasts 1 cycle with done=1, then returns to IDLE; a start in the DONE cycle is ignored.
REQ-028 num_vec is held in an internal register for the whole job; later changes on the input have no effect.
REQ-029 Address counters never wrap within a job; num_vec = 2^CNT_W-1 is supported.

Reset
REQ-030 rst_n=0 forces, asynchronously, FSM=IDLE, all counters 0, and busy, done, w_rd_en, a_rd_en, load_weight, m0, m1, phase all 0.
REQ-031 Reset asserted mid-job aborts the job with no done pulse; the first start after release runs a full job from LOAD_W.

Configuration
REQ-032 Macro SYSTOLIC_IS_SKEW_EN compiled out: all m0 rows change in the same cycle.
REQ-033 Macro SYSTOLIC_IS_SKEW_EN defined: m0 row r is delayed by r extra cycles through a shift register that resets to 0, and the drain is extended per REQ-026.

Verification
REQ-034 N=4, start with num_vec=3 -> w_addr 3,2,1,0; load_weight high for 4 cycles; m1 carries rows 3..0; m0 shows vectors 0,1,2; one done pulse; busy falls the cycle after done.
REQ-035 num_vec=0 -> only the 4 load cycles occur; a_rd_en never goes high; done pulses 1 cycle after the last load_weight.
REQ-036 start pulsed during COMPUTE and in the DONE cycle -> ignored; exactly one job runs.
REQ-037 rst_n driven low during COMPUTE with vector index 1 -> all outputs 0 immediately; no done; a later start with num_vec=2 completes normally.
REQ-038 SYSTOLIC_IS_SKEW_EN defined, N=4, one vector 0x04030201 -> row r value appears r cycles after row 0; DRAIN lasts 10 cycles.
REQ-039 Back-to-back jobs with num_vec 5 then 1 -> each job gets its own full weight load; the second run is unaffected by the first job's count.
